phase_sequencer: RTL

//  Multi-cycle phase controller for the RV32 core. Drives the 2-bit phase code consumed by the

---
 rtl/phase_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Multi-cycle phase controller for the RV32 core. Steps through
//   FETCH(0) -> DECODE(1) -> EXEC(2) -> WB(3). It handshakes with the
//   instruction and data memories, gates IR/PC/register-file commits, and
//   halts on ECALL or on a memory wait timeout.
//
// Parameters
//   TIMEOUT_W    width of the memory-wait counter
//   TIMEOUT      wait cycles without ready before timeout_err (1..2^TIMEOUT_W-1)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   run          permits a new instruction fetch
//   opcode       instr[6:0] from IR, valid from DECODE onward
//   imem_ready   instruction word valid this cycle
//   dmem_ready   data access complete this cycle
//   state        registered phase code (0=FETCH 1=DECODE 2=EXEC 3=WB)
//   imem_req     instruction fetch request
//   ir_we        IR load strobe
//   dmem_req     data memory request (load/store only)
//   pc_we        PC update strobe
//   reg_commit   register-file write gate
//   halted       sticky: sequencer stopped (cleared only by reset)
//   timeout_err  sticky: memory wait exceeded TIMEOUT (cleared only by reset)
//
// Optional feature (macro PHASE_SEQ_PERF_EN)
//   cycle_cnt    cycles with halted=0, wraps at 2^32
//   instret      WB cycles (retired instructions), wraps at 2^32

module phase_sequencer #(
    parameter int TIMEOUT_W = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic [1:0]  state,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        pc_we,
    output logic        reg_commit,
    output logic        halted,
    output logic        timeout_err
`ifdef PHASE_SEQ_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_V = TIMEOUT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } phase_t;

    phase_t               cur, nxt;
    logic [TIMEOUT_W-1:0] wait_cnt, wait_nxt;
    logic                 halt_set, terr_set;
    logic                 is_mem, is_wr;
    logic                 req_fetch, req_data;
    logic                 we_ir, we_pc, commit;

    assign state  = cur;
    assign is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign is_wr  = (opcode == OP_RTYPE) || (opcode == OP_LOAD) || (opcode == OP_IALU);

    always_comb begin
        nxt       = cur;
        wait_nxt  = wait_cnt;
        halt_set  = 1'b0;
        terr_set  = 1'b0;
        req_fetch = 1'b0;
        req_data  = 1'b0;
        we_ir     = 1'b0;
        we_pc     = 1'b0;
        commit    = 1'b0;

        case (cur)
            FETCH: begin
                req_fetch = run & ~halted;
                if (req_fetch) begin
                    if (imem_ready) begin
                        we_ir = 1'b1;
                        nxt   = DECODE;
                    end else if (wait_cnt == TIMEOUT_V) begin
                        terr_set = 1'b1;
                        halt_set = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    // idle fetch holds the wait counter at zero
                    wait_nxt = '0;
                end
            end
            DECODE: begin
                if (opcode == OP_ECALL) begin
                    halt_set = 1'b1;
                    nxt      = FETCH;
                end else begin
                    nxt = EXEC;
                end
            end
            EXEC: begin
                if (is_mem) begin
                    req_data = 1'b1;
                    if (dmem_ready) begin
                        nxt = WB;
                    end else if (wait_cnt == TIMEOUT_V) begin
                        // abort the access: back to FETCH without a WB phase
                        terr_set = 1'b1;
                        halt_set = 1'b1;
                        nxt      = FETCH;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    nxt = WB;
                end
            end
            WB: begin
                we_pc  = 1'b1;
                commit = is_wr;
                nxt    = FETCH;
            end
            default: nxt = FETCH;
        endcase

        if ((nxt != cur) || halt_set) begin
            wait_nxt = '0;
        end
    end

    // Strobes are forced low while reset is held so that every output reads
    // zero during reset, not just the registered ones.
    assign imem_req   = req_fetch & ~reset;
    assign ir_we      = we_ir     & ~reset;
    assign dmem_req   = req_data  & ~reset;
    assign pc_we      = we_pc     & ~reset;
    assign reg_commit = commit    & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= FETCH;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            if (halt_set) begin
                halted <= 1'b1;
            end
            if (terr_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef PHASE_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (!halted) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (cur == WB) begin
                instret <= instret + 32'd1;
            end
        end
    end
`endif

endmodule
